ro_freq_meter: RTL and testbench
================================

Name: ro_freq_meter

Overview:
- Measurement end of the ring-oscillator interface.
- Drives the oscillator's enable, samples its free-running, asynchronous output in the system clock domain, and counts its rising edges over a fixed gate window.
- Reports the count with a one-cycle valid pulse.
- Used for on-chip delay and process characterisation of the inverter chain.

Parameters:
- GATE_CYCLES, 1024: gate window length in clk cycles (>=1).
- SETTLE_CYCLES, 16: cycles after enabling the oscillator before counting starts (>=3, so the synchroniser is flushed).
- CNT_W, 16: width of the edge counter and the count output.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request one measurement; sampled only in IDLE.
- ro_clk  input  1  oscillator output; asynchronous to clk.
- ro_en  output  1  oscillator enable; high from SETTLE through GATE.
- busy  output  1  high in SETTLE, GATE and DONE.
- count  output  CNT_W  last completed edge count; held between measurements.
- valid  output  1  one-cycle pulse when count/overflow/alarm update.
- overflow  output  1  last measurement saturated.
- alarm  output  1  count outside limits (only with the optional feature).

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, ro_en=0, busy=0, count=0, valid=0, overflow=0, alarm=0, accumulator=0, synchroniser flops=0.
- Synchroniser and edge detect:
  - 3-flop chain s0->s1->s2 on ro_clk.
  - edge = s1 & ~s2.
  - Synchroniser latency: 2 cycles.
  - ro_clk frequency must be < f_clk/2. Faster inputs alias and are not detected or flagged.
- State IDLE:
  - start=1 -> SETTLE; set ro_en=1, busy=1.
  - Clear the accumulator and overflow accumulator.
  - Load the settle counter with SETTLE_CYCLES-1.
- State SETTLE:
  - Edges ignored.
  - Counter reaches 0 -> GATE; load the gate counter with GATE_CYCLES-1.
- State GATE:
  - Exactly GATE_CYCLES cycles.
  - In each cycle with edge=1: accumulator +1.
  - At 2^CNT_W-1, the accumulator holds its value and sets the overflow accumulator.
  - An edge in the final gate cycle is counted.
  - Counter reaches 0 -> DONE.
- State DONE:
  - Lasts one cycle.
  - Registers count<=accumulator, overflow<=overflow accumulator.
  - valid=1 in the following cycle (IDLE).
  - ro_en=0 on exit.
  - Returns to IDLE.
- Timing:
  - start sampled at edge k -> valid high in the cycle after edge k+SETTLE_CYCLES+GATE_CYCLES+1.
  - Minimum start-to-start period with start held high: SETTLE_CYCLES+GATE_CYCLES+2.
  - valid and a new start acceptance may coincide in the same IDLE cycle.
- start while busy is ignored and not queued.
- rst mid-measurement:
  - Next edge: IDLE, ro_en=0, all outputs to reset values.
  - No valid is produced.
- count, overflow and alarm change only in DONE or on reset.
- Gate and settle counter widths: $clog2 of the respective parameter +1.

Optional Feature:
- Macro: RO_FREQ_ALARM_EN.
- With the macro defined:
  - Adds parameters LOW_LIMIT (default 0) and HIGH_LIMIT (default 2^CNT_W-1).
  - In DONE, alarm <= (acc < LOW_LIMIT) | (acc > HIGH_LIMIT) | ovf_acc.
  - alarm is held until the next DONE or reset.
- Without the macro: alarm is tied to constant 0 and no comparator logic is built.

Test Plan:
- Reset check: apply rst for 3 cycles with ro_clk toggling -> ro_en=0, busy=0, count=0, valid=0, overflow=0, alarm=0.
- Nominal measurement:
  - Setup: clk 10 ns, GATE_CYCLES=1000, SETTLE_CYCLES=16, ro_clk period 100 ns driven while ro_en=1; pulse start.
  - Required: count in {99,100,101}, overflow=0, valid exactly one cycle, 1018 cycles after the start edge.
- Static oscillator: ro_clk held 0, one measurement -> count=0, valid pulses once, overflow=0.
- Saturation:
  - Setup: CNT_W=8, GATE_CYCLES=1000, ro_clk period 30 ns (~333 edges).
  - Required: count=255, overflow=1.
  - Next run at 100 ns period: count~100, overflow=0.
- Reset and start-while-busy:
  - Assert rst during gate cycle 500 -> ro_en=0 next edge, no valid.
  - Extra start pulses while busy=1 -> ignored; exactly one valid per accepted start.
  - start held high -> valid pulses every 1018 cycles.
- Alarm (RO_FREQ_ALARM_EN, LOW_LIMIT=90, HIGH_LIMIT=110):
  - ro_clk 100 ns -> alarm=0.
  - ro_clk 200 ns (count~50) -> alarm=1.
  - Without the macro -> alarm=0 always.

Source files
------------

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronised ro_clk rising edges over a fixed gate window.
// Optional limit alarm is built only when RO_FREQ_ALARM_EN is defined.
module ro_freq_meter #(
  parameter int GATE_CYCLES   = 1024,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 16
`ifdef RO_FREQ_ALARM_EN
  ,
  parameter logic [CNT_W-1:0] LOW_LIMIT  = {CNT_W{1'b0}},
  parameter logic [CNT_W-1:0] HIGH_LIMIT = {CNT_W{1'b1}}
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ro_clk,
  output logic             ro_en,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic             overflow,
  output logic             alarm
);

  localparam int GW = $clog2(GATE_CYCLES) + 1;
  localparam int SW = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [GW-1:0]    GATE_LOAD   = GW'(GATE_CYCLES - 1);
  localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [GW-1:0]    GATE_ONE    = GW'(1);
  localparam logic [SW-1:0]    SETTLE_ONE  = SW'(1);
  localparam logic [CNT_W-1:0] ACC_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ACC_MAX     = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_GATE   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [2:0]       sync_r;
  logic             edge_s;
  logic [SW-1:0]    settle_cnt_r, settle_cnt_s;
  logic [GW-1:0]    gate_cnt_r, gate_cnt_s;
  logic [CNT_W-1:0] acc_r, acc_s;
  logic [CNT_W-1:0] count_r, count_s;
  logic             ovf_acc_r, ovf_acc_s;
  logic             overflow_r, overflow_s;
  logic             ro_en_r, ro_en_s;
  logic             busy_r, busy_s;
  logic             valid_r, valid_s;
`ifdef RO_FREQ_ALARM_EN
  logic             alarm_r, alarm_s;
`endif

  // sync_r[1] is the first metastability-safe stage; sync_r[2] is its delayed copy
  assign edge_s = sync_r[1] & ~sync_r[2];

  // Next-state, counter, accumulator and output-register decode
  always_comb begin
    state_s      = state_r;
    settle_cnt_s = settle_cnt_r;
    gate_cnt_s   = gate_cnt_r;
    acc_s        = acc_r;
    ovf_acc_s    = ovf_acc_r;
    count_s      = count_r;
    overflow_s   = overflow_r;
    ro_en_s      = ro_en_r;
    busy_s       = busy_r;
    valid_s      = 1'b0;
`ifdef RO_FREQ_ALARM_EN
    alarm_s      = alarm_r;
`endif
    case (state_r)
      ST_IDLE: begin
        acc_s     = {CNT_W{1'b0}};
        ovf_acc_s = 1'b0;
        if (start) begin
          state_s      = ST_SETTLE;
          settle_cnt_s = SETTLE_LOAD;
          ro_en_s      = 1'b1;
          busy_s       = 1'b1;
        end else begin
          ro_en_s = 1'b0;
          busy_s  = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_r == {SW{1'b0}}) begin
          state_s    = ST_GATE;
          gate_cnt_s = GATE_LOAD;
        end else begin
          settle_cnt_s = settle_cnt_r - SETTLE_ONE;
        end
      end
      ST_GATE: begin
        // Saturate instead of wrapping so an over-range result stays recognisable
        if (edge_s && (acc_r == ACC_MAX)) begin
          ovf_acc_s = 1'b1;
        end else if (edge_s) begin
          acc_s = acc_r + ACC_ONE;
        end else begin
          acc_s = acc_r;
        end
        if (gate_cnt_r == {GW{1'b0}}) begin
          state_s = ST_DONE;
        end else begin
          gate_cnt_s = gate_cnt_r - GATE_ONE;
        end
      end
      ST_DONE: begin
        count_s    = acc_r;
        overflow_s = ovf_acc_r;
        valid_s    = 1'b1;
        ro_en_s    = 1'b0;
        busy_s     = 1'b0;
        state_s    = ST_IDLE;
`ifdef RO_FREQ_ALARM_EN
        alarm_s    = (acc_r < LOW_LIMIT) | (acc_r > HIGH_LIMIT) | ovf_acc_r;
`endif
      end
      default: begin
        state_s = ST_IDLE;
        ro_en_s = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, synchroniser and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      sync_r       <= 3'b000;
      settle_cnt_r <= {SW{1'b0}};
      gate_cnt_r   <= {GW{1'b0}};
      acc_r        <= {CNT_W{1'b0}};
      ovf_acc_r    <= 1'b0;
      count_r      <= {CNT_W{1'b0}};
      overflow_r   <= 1'b0;
      ro_en_r      <= 1'b0;
      busy_r       <= 1'b0;
      valid_r      <= 1'b0;
`ifdef RO_FREQ_ALARM_EN
      alarm_r      <= 1'b0;
`endif
    end else begin
      state_r      <= state_s;
      sync_r       <= {sync_r[1:0], ro_clk};
      settle_cnt_r <= settle_cnt_s;
      gate_cnt_r   <= gate_cnt_s;
      acc_r        <= acc_s;
      ovf_acc_r    <= ovf_acc_s;
      count_r      <= count_s;
      overflow_r   <= overflow_s;
      ro_en_r      <= ro_en_s;
      busy_r       <= busy_s;
      valid_r      <= valid_s;
`ifdef RO_FREQ_ALARM_EN
      alarm_r      <= alarm_s;
`endif
    end
  end

  assign ro_en    = ro_en_r;
  assign busy     = busy_r;
  assign count    = count_r;
  assign valid    = valid_r;
  assign overflow = overflow_r;
`ifdef RO_FREQ_ALARM_EN
  assign alarm    = alarm_r;
`else
  assign alarm    = 1'b0;
`endif

endmodule

// File: tb/tb_ro_freq_meter.sv
// Bench for ro_freq_meter: window-count model of the sampled oscillator plus directed scenarios.
module tb_ro_freq_meter;

  localparam int G   = 1000;
  localparam int S   = 16;
  localparam int W   = 8;
  localparam int MAXV = 255;
  localparam int PERIOD = S + G + 2;

  logic         clk, rst, start, ro_clk;
  logic         ro_en, busy, valid, overflow, alarm;
  logic [W-1:0] count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ro_half = 50;

  bit samp [0:32767];
  int m_k = -1000000;
  int m_done = -1;
  int m_count = 0;
  bit m_ovf = 1'b0;
  bit m_alarm = 1'b0;
  bit m_known = 1'b0;

  int vcnt = 0;
  int last_v = -1;
  int vq[$];

  ro_freq_meter #(
    .GATE_CYCLES(G),
    .SETTLE_CYCLES(S),
    .CNT_W(W)
`ifdef RO_FREQ_ALARM_EN
    ,
    .LOW_LIMIT(8'd90),
    .HIGH_LIMIT(8'd110)
`endif
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ro_clk(ro_clk),
    .ro_en(ro_en), .busy(busy), .count(count), .valid(valid),
    .overflow(overflow), .alarm(alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oscillator: toggles land 2 or 7 units past a 10-unit boundary, never on a clk edge
  initial begin
    ro_clk = 1'b0;
    #2;
    forever begin
      if (ro_half == 0) begin
        ro_clk = 1'b0;
        #10;
      end else begin
        #(ro_half);
        ro_clk = ~ro_clk;
      end
    end
  end

  // Model: a measurement accepted at edge k reports the rising transitions of the
  // clk-sampled oscillator seen at samples k+S-1 .. k+S+G-2 (two-cycle synchroniser lag).
  always @(posedge clk) begin
    int e;
    cyc = cyc + 1;
    samp[cyc] = ro_clk;
    if (rst) begin
      m_known = 1'b1;
      m_k = -1000000;
      m_done = -1;
      m_count = 0;
      m_ovf = 1'b0;
      m_alarm = 1'b0;
    end else begin
      if (cyc == m_done) begin
        e = 0;
        for (int t = m_k + S - 1; t <= m_k + S + G - 2; t++)
          if (samp[t] && !samp[t-1]) e++;
        m_count = (e > MAXV) ? MAXV : e;
        m_ovf = (e > MAXV);
`ifdef RO_FREQ_ALARM_EN
        m_alarm = (m_count < 90) || (m_count > 110) || m_ovf;
`else
        m_alarm = 1'b0;
`endif
      end else if (start && cyc > m_done) begin
        m_k = cyc;
        m_done = cyc + S + G + 1;
      end
    end
  end

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    bit e_busy, e_valid;
    if (m_known) begin
      e_busy  = (cyc >= m_k) && (cyc < m_done);
      e_valid = (cyc == m_done);
      total++;
      if ({ro_en, busy, valid, overflow, alarm} !== {e_busy, e_busy, e_valid, m_ovf, m_alarm} ||
          count !== W'(m_count)) begin
        bad++;
        $display("FAIL cycle_check n=%0d got en/busy/valid/ovf/alarm/count=%b%b%b%b%b/%0d exp %b%b%b%b%b/%0d",
                 cyc, ro_en, busy, valid, overflow, alarm, count,
                 e_busy, e_busy, e_valid, m_ovf, m_alarm, m_count);
      end
      if (valid === 1'b1) begin
        vcnt++;
        last_v = cyc;
        vq.push_back(cyc);
      end
    end
  end

  task automatic chk(input string name, input int got, input int lo, input int hi);
    total++;
    if (got < lo || got > hi) begin
      bad++;
      $display("FAIL %s got=%0d want=[%0d..%0d]", name, got, lo, hi);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(output int k);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = cyc;
  endtask

  // One full measurement; returns edge of acceptance and the valid count before it
  task automatic measure(input int half, output int k, output int v0);
    ro_half = half;
    wait_cyc(30);
    v0 = vcnt;
    pulse_start(k);
    wait_cyc(PERIOD + 2);
  endtask

  initial begin
    int k, v0;
    rst = 1'b1;
    start = 1'b0;
    wait_cyc(3);
    chk("reset_ro_en", int'(ro_en), 0, 0);
    chk("reset_busy", int'(busy), 0, 0);
    chk("reset_count", int'(count), 0, 0);
    chk("reset_valid", int'(valid), 0, 0);
    chk("reset_ovf", int'(overflow), 0, 0);
    chk("reset_alarm", int'(alarm), 0, 0);
    rst = 1'b0;

    // Nominal 100-unit oscillator: about 100 edges in 1000 cycles
    measure(50, k, v0);
    chk("nominal_count", int'(count), 99, 101);
    chk("nominal_ovf", int'(overflow), 0, 0);
    chk("nominal_valid_once", vcnt - v0, 1, 1);
    chk("nominal_latency", last_v + 1 - k, 1018, 1018);
`ifdef RO_FREQ_ALARM_EN
    chk("nominal_alarm", int'(alarm), 0, 0);
`else
    chk("nominal_alarm", int'(alarm), 0, 0);
`endif

    // Static oscillator
    measure(0, k, v0);
    chk("static_count", int'(count), 0, 0);
    chk("static_ovf", int'(overflow), 0, 0);
    chk("static_valid_once", vcnt - v0, 1, 1);

    // Saturation: ~333 edges into an 8-bit counter
    measure(15, k, v0);
    chk("sat_count", int'(count), 255, 255);
    chk("sat_ovf", int'(overflow), 1, 1);

    // Back to nominal clears the overflow
    measure(50, k, v0);
    chk("renom_count", int'(count), 99, 101);
    chk("renom_ovf", int'(overflow), 0, 0);

    // Reset during gate cycle 500
    v0 = vcnt;
    pulse_start(k);
    wait_cyc(S + 500 - 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ro_en", int'(ro_en), 0, 0);
    chk("midrst_busy", int'(busy), 0, 0);
    wait_cyc(PERIOD + 10);
    chk("midrst_no_valid", vcnt - v0, 0, 0);
    chk("midrst_count", int'(count), 0, 0);

    // Extra starts while busy are ignored
    v0 = vcnt;
    pulse_start(k);
    wait_cyc(100);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_cyc(400);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_cyc(508);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_cyc(30);
    chk("busy_start_one_valid", vcnt - v0, 1, 1);
    chk("busy_start_latency", last_v + 1 - k, 1018, 1018);

    // start held high: back-to-back measurements every PERIOD cycles
    wait_cyc(10);
    v0 = vcnt;
    start = 1'b1;
    wait_cyc(3000);
    start = 1'b0;
    wait_cyc(1100);
    chk("held_valid_count", vcnt - v0, 3, 3);
    chk("held_interval_a", vq[vq.size()-1] - vq[vq.size()-2], 1018, 1018);
    chk("held_interval_b", vq[vq.size()-2] - vq[vq.size()-3], 1018, 1018);

    // Slow oscillator: about 50 edges
    measure(100, k, v0);
    chk("slow_count", int'(count), 49, 51);
`ifdef RO_FREQ_ALARM_EN
    chk("slow_alarm", int'(alarm), 1, 1);
`else
    chk("slow_alarm", int'(alarm), 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
